// File: rtl/pong_pkg.sv
// Shared Pong definitions: position width, court geometry and the
// paddle state/direction types used by the player input stage.
package pong_pkg;

    localparam int POS_W       = 10;
    localparam int ARITH_W     = POS_W + 1;
    localparam int HOLD_W      = 5;

    localparam int SCREEN_H    = 480;
    localparam int PADDLE_H    = 64;
    localparam int BORDER      = 8;
    localparam int PADDLE_HALF = PADDLE_H / 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UP        = 3'd1,
        ST_DOWN      = 3'd2,
        ST_UP_FAST   = 3'd3,
        ST_DOWN_FAST = 3'd4
    } paddle_st_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // Saturating increment for the held-direction frame counter.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == '1) ? v : v + HOLD_W'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer. The
// debounced level flips only after the synchronised input has disagreed
// with it for 2^DEB_BITS - 1 consecutive cycles.
module button_debounce
    import pong_pkg::*;
#(
    parameter int DEB_BITS = 16
)(
    input  logic px_clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_deb
);

    logic [1:0]          r_sync;
    logic [DEB_BITS-1:0] r_cnt;
    logic                r_deb;

    // Synchronise the raw button and run the stability counter.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == '1) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DEB_BITS'(1);
            end
        end
    end

    assign btn_deb = r_deb;

endmodule

// File: rtl/paddle_ctrl.sv
// Player input stage: debounced buttons drive one paddle FSM per player,
// positions step once per frame tick and are clamped to the court.
// Build option: PADDLE_AI_EN makes player 2 track the ball row instead
// of its buttons (slow speed only).
//
// state        | meaning
// -------------+------------------------------------------
// ST_IDLE      | no direction requested, paddle still
// ST_UP        | moving up by SPEED per frame
// ST_DOWN      | moving down by SPEED per frame
// ST_UP_FAST   | up held long enough, 2*SPEED per frame
// ST_DOWN_FAST | down held long enough, 2*SPEED per frame
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int POS_MIN     = BORDER,
    parameter int POS_MAX     = SCREEN_H - PADDLE_H - BORDER,
    parameter int POS_INIT    = 208,
    parameter int SPEED       = 4,
    parameter int HOLD_FRAMES = 16,
    parameter int DEB_BITS    = 16
)(
    input  logic             px_clk,
    input  logic             reset,
    input  logic             endframe,
    input  logic             btn_up1,
    input  logic             btn_dn1,
    input  logic             btn_up2,
    input  logic             btn_dn2,
    input  logic [POS_W-1:0] y_ball,
    output logic [POS_W-1:0] pos_ply1,
    output logic [POS_W-1:0] pos_ply2
);

    localparam logic [ARITH_W-1:0] L_MIN   = ARITH_W'(POS_MIN);
    localparam logic [ARITH_W-1:0] L_MAX   = ARITH_W'(POS_MAX);
    localparam logic [ARITH_W-1:0] L_STEP  = ARITH_W'(SPEED);
    localparam logic [ARITH_W-1:0] L_STEP2 = ARITH_W'(2 * SPEED);
    localparam logic [HOLD_W-1:0]  L_HOLD  = HOLD_W'(HOLD_FRAMES);
    localparam logic [POS_W-1:0]   L_INIT  = POS_W'(POS_INIT);

    logic [1:0]         w_up;
    logic [1:0]         w_dn;
    logic [1:0]         w_fast_ok;
    logic               r_ef_d;
    logic               r_armed;
    logic               w_tick;
    dir_t               w_req      [2];
    paddle_st_t         r_st       [2];
    paddle_st_t         w_st_nxt   [2];
    logic [HOLD_W-1:0]  r_hold     [2];
    logic [HOLD_W-1:0]  w_hold_nxt [2];
    logic [HOLD_W-1:0]  w_hold_inc [2];
    logic [POS_W-1:0]   r_pos      [2];
    logic [POS_W-1:0]   w_pos_nxt  [2];
    logic [ARITH_W-1:0] w_step     [2];
    logic [ARITH_W-1:0] w_calc     [2];

    button_debounce #(.DEB_BITS(DEB_BITS)) u_deb_up1 (
        .px_clk(px_clk), .reset(reset), .btn_raw(btn_up1), .btn_deb(w_up[0])
    );
    button_debounce #(.DEB_BITS(DEB_BITS)) u_deb_dn1 (
        .px_clk(px_clk), .reset(reset), .btn_raw(btn_dn1), .btn_deb(w_dn[0])
    );

`ifdef PADDLE_AI_EN
    logic               w_unused_btn;
    logic [ARITH_W-1:0] w_tgt;
    assign w_unused_btn = btn_up2 ^ btn_dn2;
    assign w_up[1]      = 1'b0;
    assign w_dn[1]      = 1'b0;
    assign w_fast_ok    = 2'b01;
`else
    logic w_unused_y;
    assign w_unused_y = ^y_ball;
    assign w_fast_ok  = 2'b11;
    button_debounce #(.DEB_BITS(DEB_BITS)) u_deb_up2 (
        .px_clk(px_clk), .reset(reset), .btn_raw(btn_up2), .btn_deb(w_up[1])
    );
    button_debounce #(.DEB_BITS(DEB_BITS)) u_deb_dn2 (
        .px_clk(px_clk), .reset(reset), .btn_raw(btn_dn2), .btn_deb(w_dn[1])
    );
`endif

    // Frame tick on the rising edge of endframe; r_armed blocks a tick
    // until endframe has been seen low after reset.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_ef_d  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_ef_d <= endframe;
            if (!endframe) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_tick = endframe & ~r_ef_d & r_armed;

    // Direction request per player (buttons, or ball tracking for player 2).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_req[p] = DIR_NONE;
            if (w_up[p] && !w_dn[p]) begin
                w_req[p] = DIR_UP;
            end else if (w_dn[p] && !w_up[p]) begin
                w_req[p] = DIR_DN;
            end
        end
`ifdef PADDLE_AI_EN
        w_tgt = {1'b0, y_ball} - ARITH_W'(PADDLE_HALF);
        if ({1'b0, y_ball} < L_MIN + ARITH_W'(PADDLE_HALF)) begin
            w_tgt = L_MIN;
        end else if (w_tgt > L_MAX) begin
            w_tgt = L_MAX;
        end
        w_req[1] = DIR_NONE;
        if (w_tgt > {1'b0, r_pos[1]} + L_STEP) begin
            w_req[1] = DIR_DN;
        end else if ({1'b0, r_pos[1]} > w_tgt + L_STEP) begin
            w_req[1] = DIR_UP;
        end
`endif
    end

    // Next state, hold counter and clamped position, evaluated on tick only.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_st_nxt[p]   = r_st[p];
            w_hold_nxt[p] = r_hold[p];
            w_pos_nxt[p]  = r_pos[p];
            w_hold_inc[p] = sat_inc(r_hold[p]);
            w_step[p]     = '0;
            w_calc[p]     = {1'b0, r_pos[p]};
            if (w_tick) begin
                case (w_req[p])
                    DIR_UP: begin
                        if (r_st[p] == ST_UP || r_st[p] == ST_UP_FAST) begin
                            w_hold_nxt[p] = w_hold_inc[p];
                            if (w_fast_ok[p] && (r_st[p] == ST_UP_FAST || w_hold_inc[p] >= L_HOLD))
                                w_st_nxt[p] = ST_UP_FAST;
                            else
                                w_st_nxt[p] = ST_UP;
                        end else begin
                            w_st_nxt[p]   = ST_UP;
                            w_hold_nxt[p] = '0;
                        end
                    end
                    DIR_DN: begin
                        if (r_st[p] == ST_DOWN || r_st[p] == ST_DOWN_FAST) begin
                            w_hold_nxt[p] = w_hold_inc[p];
                            if (w_fast_ok[p] && (r_st[p] == ST_DOWN_FAST || w_hold_inc[p] >= L_HOLD))
                                w_st_nxt[p] = ST_DOWN_FAST;
                            else
                                w_st_nxt[p] = ST_DOWN;
                        end else begin
                            w_st_nxt[p]   = ST_DOWN;
                            w_hold_nxt[p] = '0;
                        end
                    end
                    default: begin
                        w_st_nxt[p]   = ST_IDLE;
                        w_hold_nxt[p] = '0;
                    end
                endcase

                case (w_st_nxt[p])
                    ST_UP, ST_DOWN:           w_step[p] = L_STEP;
                    ST_UP_FAST, ST_DOWN_FAST: w_step[p] = L_STEP2;
                    default:                  w_step[p] = '0;
                endcase

                if (w_st_nxt[p] == ST_UP || w_st_nxt[p] == ST_UP_FAST) begin
                    w_calc[p] = {1'b0, r_pos[p]} - w_step[p];
                    if (w_calc[p][ARITH_W-1] || w_calc[p] < L_MIN)
                        w_calc[p] = L_MIN;
                end else if (w_st_nxt[p] == ST_DOWN || w_st_nxt[p] == ST_DOWN_FAST) begin
                    w_calc[p] = {1'b0, r_pos[p]} + w_step[p];
                    if (w_calc[p] > L_MAX)
                        w_calc[p] = L_MAX;
                end
                w_pos_nxt[p] = w_calc[p][POS_W-1:0];
            end
        end
    end

    // Paddle state, hold counters and position registers.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_st[p]   <= ST_IDLE;
                r_hold[p] <= '0;
                r_pos[p]  <= L_INIT;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_st[p]   <= w_st_nxt[p];
                r_hold[p] <= w_hold_nxt[p];
                r_pos[p]  <= w_pos_nxt[p];
            end
        end
    end

    assign pos_ply1 = r_pos[0];
    assign pos_ply2 = r_pos[1];

endmodule
